// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - arbiter state encoding
package mem_arb_pkg;
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DATA,
        ST_DONE
    } arb_state_e;
endpackage

// File: rtl/sys_defs.sv
// rtl/sys_defs.sv - shared bus command encodings
package sys_defs;
    localparam logic [1:0] BUS_NONE  = 2'd0;
    localparam logic [1:0] BUS_LOAD  = 2'd1;
    localparam logic [1:0] BUS_STORE = 2'd2;
endpackage

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - arbitrates IF fetches and MEM loads/stores onto one memory port
module mem_arbiter
    import sys_defs::*;
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT      = 16,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        if_flush,
    output logic [31:0] if_rdata,
    output logic        if_valid,
    output logic        if_stall,
    input  logic [1:0]  d_cmd,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_done,
    output logic        d_stall,
    output logic        bus_err,
    output logic [1:0]  mem_cmd,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [WW-1:0] WAIT_LAST  = WW'(TIMEOUT - 1);

    arb_state_e  state_q, state_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [WW-1:0] wait_q, wait_d;
    logic        kill_q, kill_d;
    logic        fetch_q, fetch_d;
    logic        err_q, err_d;
    logic [1:0]  cmd_q, cmd_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic        data_grant, fetch_grant;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            starve_q   <= '0;
            wait_q     <= '0;
            kill_q     <= 1'b0;
            fetch_q    <= 1'b0;
            err_q      <= 1'b0;
            cmd_q      <= BUS_NONE;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            starve_q   <= starve_d;
            wait_q     <= wait_d;
            kill_q     <= kill_d;
            fetch_q    <= fetch_d;
            err_q      <= err_d;
            cmd_q      <= cmd_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        wait_d      = wait_q;
        kill_d      = kill_q;
        fetch_d     = fetch_q;
        err_d       = err_q;
        cmd_d       = cmd_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        data_grant  = 1'b0;
        fetch_grant = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (d_cmd != BUS_NONE && (starve_q < STARVE_MAX || !if_req)) begin
                    data_grant = 1'b1;
                    state_d    = ST_DATA;
                    fetch_d    = 1'b0;
                    cmd_d      = d_cmd;
                    addr_d     = d_addr;
                    wdata_d    = d_wdata;
                    wait_d     = '0;
                end else if (if_req && !if_flush) begin
                    fetch_grant = 1'b1;
                    state_d     = ST_FETCH;
                    fetch_d     = 1'b1;
                    cmd_d       = BUS_LOAD;
                    addr_d      = if_addr;
                    wdata_d     = '0;
                    wait_d      = '0;
                end
            end
            ST_FETCH, ST_DATA: begin
                // A flush coinciding with mem_ack still kills the fetch: kill_q lands with DONE.
                if (state_q == ST_FETCH && if_flush) begin
                    kill_d = 1'b1;
                end
                if (mem_ack) begin
                    state_d = ST_DONE;
                    cmd_d   = BUS_NONE;
                    if (fetch_q) begin
                        if_rdata_d = mem_rdata;
                    end else begin
                        d_rdata_d = (cmd_q == BUS_STORE) ? '0 : mem_rdata;
                    end
                end else if (wait_q == WAIT_LAST) begin
                    state_d = ST_DONE;
                    cmd_d   = BUS_NONE;
                    err_d   = 1'b1;
                    if (fetch_q) begin
                        if_rdata_d = '0;
                    end else begin
                        d_rdata_d = '0;
                    end
                end else begin
                    wait_d = wait_q + WW'(1);
                end
            end
            ST_DONE: begin
                kill_d  = 1'b0;
                err_d   = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (!if_req || fetch_grant) begin
            starve_d = '0;
        end else if (data_grant && starve_q != STARVE_MAX) begin
            starve_d = starve_q + SW'(1);
        end
    end

    assign if_valid  = (state_q == ST_DONE) & fetch_q & ~kill_q;
    assign d_done    = (state_q == ST_DONE) & ~fetch_q;
    assign bus_err   = (state_q == ST_DONE) & err_q;
    assign if_stall  = if_req & ~if_valid;
    assign d_stall   = (d_cmd != BUS_NONE) & ~d_done;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign mem_cmd   = cmd_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
endmodule
